ldr_bridge: RTL and testbench

LDR_BRIDGE -- requirements
Module: ldr_bridge

---
 rtl/ldr_bridge_if.sv | 33 +++
 rtl/ldr_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_ldr_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldr_bridge_if.sv
// Signal bundle between the HPS ioctl download port, the loader bridge and its target.
// slave is the bridge's view, master is the HPS/target side's view.
interface ldr_bridge_if #(
  parameter int DW  = 16,
  parameter int AW  = 20,
  parameter int NCH = 4
);
  logic            ioctl_download;
  logic [7:0]      ioctl_index;
  logic            ioctl_wr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;

  logic [AW-1:0]   ldr_addr;
  logic [DW-1:0]   ldr_wdat;
  logic [2:0]      ldr_ch;
  logic            ldr_wr;
  logic            ldr_ack;
  logic [NCH-1:0]  ldr_done;
  logic            ldr_busy;
  logic [15:0]     ldr_sum;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_addr, ldr_wdat, ldr_ch, ldr_wr, ldr_done, ldr_busy, ldr_sum
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_addr, ldr_wdat, ldr_ch, ldr_wr, ldr_done, ldr_busy, ldr_sum
  );
endinterface

// File: rtl/ldr_bridge.sv
// Byte-stream loader bridge: packs ioctl bytes into DW words, buffers them in a FIFO and
// replays them to a channel with an edge-acknowledged write. Optional: LDR_BRIDGE_CHECKSUM_EN.
module ldr_bridge #(
  parameter int DW    = 16,
  parameter int AW    = 20,
  parameter int DEPTH = 8,
  parameter int NCH   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  ldr_bridge_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FLUSH} state_t;

  state_t          r_state, w_state_nx;
  logic            r_dl_q, r_ack_q;
  logic            w_dl_rise, w_dl_fall, w_ack_rise;
  logic            w_idx_ok, w_byte;
  logic            w_enter_load, w_flush, w_finish;
  logic [2:0]      r_ch;
  logic [NCH-1:0]  r_done;

  logic            w_byte_push, w_pend;
  logic [AW-1:0]   w_byte_addr, w_flush_addr, w_push_addr;
  logic [DW-1:0]   w_byte_dat, w_flush_dat, w_push_dat;
  logic            w_push, w_pop, w_full, w_push_ok;

  logic [AW-1:0]   r_mem_a [DEPTH];
  logic [DW-1:0]   r_mem_d [DEPTH];
  logic [2:0]      r_mem_c [DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_ovf;
  logic            r_wait;

  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdat;
  logic [2:0]      r_och;

  assign w_dl_rise  = bus.ioctl_download & ~r_dl_q;
  assign w_dl_fall  = ~bus.ioctl_download & r_dl_q;
  assign w_ack_rise = bus.ldr_ack & ~r_ack_q;
  assign w_idx_ok   = bus.ioctl_index < 8'(NCH);
  assign w_byte     = (r_state == LOAD) && bus.ioctl_download && bus.ioctl_wr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_q  <= 1'b0;
      r_ack_q <= 1'b0;
    end else begin
      r_dl_q  <= bus.ioctl_download;
      r_ack_q <= bus.ldr_ack;
    end
  end

  // Byte packer: DW=8 pushes every byte, DW=16 pairs low/high bytes by addr[0]
  generate
    if (DW == 8) begin : g_pack8
      logic w_unused;
      assign w_unused     = ^bus.ioctl_addr[24:AW];
      assign w_byte_push  = w_byte;
      assign w_byte_addr  = bus.ioctl_addr[AW-1:0];
      assign w_byte_dat   = DW'(bus.ioctl_dout);
      assign w_pend       = 1'b0;
      assign w_flush_addr = '0;
      assign w_flush_dat  = '0;
    end else begin : g_pack16
      logic          r_pend;
      logic [7:0]    r_lo;
      logic [AW-1:0] r_lo_addr;
      logic          w_unused;
      assign w_unused = ^bus.ioctl_addr[24:AW+1];

      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          r_pend    <= 1'b0;
          r_lo      <= 8'h00;
          r_lo_addr <= '0;
        end else if (w_enter_load || w_flush) begin
          r_pend <= 1'b0;
        end else if (w_byte) begin
          if (!bus.ioctl_addr[0]) begin
            r_lo      <= bus.ioctl_dout;
            r_lo_addr <= bus.ioctl_addr[AW:1];
            r_pend    <= 1'b1;
          end else begin
            r_pend <= 1'b0;
          end
        end
      end

      assign w_byte_push  = w_byte && bus.ioctl_addr[0];
      assign w_byte_addr  = bus.ioctl_addr[AW:1];
      assign w_byte_dat   = DW'({bus.ioctl_dout, r_lo});
      assign w_pend       = r_pend;
      assign w_flush_addr = r_lo_addr;
      assign w_flush_dat  = DW'({8'h00, r_lo});
    end
  endgenerate

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_enter_load = 1'b0;
    w_flush      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE:  if (w_dl_rise && w_idx_ok) begin
               w_state_nx   = LOAD;
               w_enter_load = 1'b1;
             end
      LOAD:  if (w_dl_fall) w_state_nx = w_pend ? FLUSH : DRAIN;
      FLUSH: begin
               w_flush    = 1'b1;
               w_state_nx = DRAIN;
             end
      DRAIN: if (r_cnt == '0 && !r_wr) begin
               w_finish   = 1'b1;
               w_state_nx = IDLE;
             end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_ch <= 3'd0;
    else if (w_enter_load) r_ch <= bus.ioctl_index[2:0];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_done <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_enter_load && bus.ioctl_index == 8'(i)) r_done[i] <= 1'b0;
        if (w_finish && r_ch == 3'(i))                r_done[i] <= 1'b1;
      end
    end
  end

  // FIFO: a full FIFO still accepts a push when the head pops in the same cycle
  assign w_push      = w_byte_push | w_flush;
  assign w_push_addr = w_flush ? w_flush_addr : w_byte_addr;
  assign w_push_dat  = w_flush ? w_flush_dat  : w_byte_dat;
  assign w_pop       = r_wr && w_ack_rise;
  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_cnt_nx    = r_cnt + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge clk_sys) begin
    if (w_push_ok) begin
      r_mem_a[r_wp] <= w_push_addr;
      r_mem_d[r_wp] <= w_push_dat;
      r_mem_c[r_wp] <= r_ch;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_wait <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      r_cnt  <= w_cnt_nx;
      r_wait <= (w_cnt_nx >= CW'(DEPTH - 2));
    end
  end

  // Output stage holds the head word until an ack rising edge; one idle cycle after each pop
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_wdat <= '0;
      r_och  <= 3'd0;
    end else if (w_pop) begin
      r_wr <= 1'b0;
    end else if (!r_wr && r_cnt != '0) begin
      r_wr   <= 1'b1;
      r_addr <= r_mem_a[r_rp];
      r_wdat <= r_mem_d[r_rp];
      r_och  <= r_mem_c[r_rp];
    end
  end

`ifdef LDR_BRIDGE_CHECKSUM_EN
  logic [15:0] r_sum;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)             r_sum <= 16'h0000;
    else if (w_enter_load) r_sum <= 16'h0000;
    else if (w_byte)       r_sum <= r_sum + 16'(bus.ioctl_dout);
  end
  assign bus.ldr_sum = r_sum;
`else
  assign bus.ldr_sum = 16'h0000;
`endif

  // Overflow is a debug-only sticky bit with no port
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf;

  assign bus.ioctl_wait = r_wait;
  assign bus.ldr_wr     = r_wr;
  assign bus.ldr_addr   = r_addr;
  assign bus.ldr_wdat   = r_wdat;
  assign bus.ldr_ch     = r_och;
  assign bus.ldr_done   = r_done;
  assign bus.ldr_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_ldr_bridge.sv
// Directed bench for ldr_bridge (DW=16, DEPTH=8, NCH=4): writes observed on the target side
// are queued by a monitor and compared against hand-computed words.
module tb_ldr_bridge;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  int   stab_err = 0;

  always #5 clk_sys = ~clk_sys;

  ldr_bridge_if #(.DW(16), .AW(20), .NCH(4)) bus();
  ldr_bridge #(.DW(16), .AW(20), .DEPTH(8), .NCH(4)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus)
  );

  `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end end

  typedef struct { logic [19:0] a; logic [15:0] d; logic [2:0] c; } wr_t;
  wr_t q[$];

  logic auto_mode = 1'b1;
  logic auto_ack  = 1'b0;
  logic man_ack   = 1'b0;
  int   acnt      = 0;
  assign bus.ldr_ack = auto_mode ? auto_ack : man_ack;

  // target model: raise ack two cycles after ldr_wr appears
  always @(negedge clk_sys) begin
    if (!bus.ldr_wr) begin
      auto_ack = 1'b0;
      acnt = 0;
    end else if (!auto_ack) begin
      acnt++;
      if (acnt == 2) auto_ack = 1'b1;
    end
  end

  logic prev_wr = 1'b0;
  wr_t  cur;
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_wr = 1'b0;
    end else begin
      if (bus.ldr_wr && !prev_wr) begin
        cur.a = bus.ldr_addr; cur.d = bus.ldr_wdat; cur.c = bus.ldr_ch;
        q.push_back(cur);
      end else if (bus.ldr_wr && prev_wr) begin
        if (bus.ldr_addr !== cur.a || bus.ldr_wdat !== cur.d || bus.ldr_ch !== cur.c) stab_err++;
      end
      prev_wr = bus.ldr_wr;
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk_sys);
    while (bus.ioctl_wait && n < 200) begin @(negedge clk_sys); n++; end
    if (n >= 200) `CHK("wait_timeout", bus.ioctl_wait, 1'b0)
    bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.ldr_busy && n < 500) begin @(negedge clk_sys); n++; end
    if (n >= 500) `CHK("idle_timeout", bus.ldr_busy, 1'b0)
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!bus.ldr_wr && n < 200) begin @(negedge clk_sys); n++; end
    if (n >= 200) `CHK("wr_timeout", bus.ldr_wr, 1'b1)
  endtask

  task automatic ack_pulse();
    wait_wr();
    man_ack = 1'b1;
    @(negedge clk_sys);
    man_ack = 1'b0;
    @(negedge clk_sys);
  endtask

  logic [15:0] exp_sum;
  logic        ok;
  logic [7:0]  b_lo, b_hi;
  int          i, words_at;
  logic        seen;

  initial begin
`ifdef LDR_BRIDGE_CHECKSUM_EN
    exp_sum = 16'h0231;
`else
    exp_sum = 16'h0000;
`endif
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'h0; bus.ioctl_dout = 8'h00;

    // reset state
    repeat (3) @(negedge clk_sys);
    `CHK("rst_wr",   bus.ldr_wr,     1'b0)
    `CHK("rst_wait", bus.ioctl_wait, 1'b0)
    `CHK("rst_done", bus.ldr_done,   4'h0)
    `CHK("rst_busy", bus.ldr_busy,   1'b0)
    `CHK("rst_sum",  bus.ldr_sum,    16'h0)
    `CHK("rst_addr", bus.ldr_addr,   20'h0)
    `CHK("rst_wdat", bus.ldr_wdat,   16'h0)
    `CHK("rst_ch",   bus.ldr_ch,     3'h0)
    reset = 1'b0;

    // basic 2-word download on channel 0
    start_dl(8'd0);
    `CHK("a_busy", bus.ldr_busy, 1'b1)
    send_byte(25'd0, 8'h11); send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33); send_byte(25'd3, 8'h44);
    end_dl();
    wait_idle();
    `CHK("a_nwr", q.size(), 2)
    if (q.size() == 2) begin
      `CHK("a_w0_addr", q[0].a, 20'd0)
      `CHK("a_w0_dat",  q[0].d, 16'h2211)
      `CHK("a_w1_addr", q[1].a, 20'd1)
      `CHK("a_w1_dat",  q[1].d, 16'h4433)
      `CHK("a_w1_ch",   q[1].c, 3'd0)
    end
    `CHK("a_done", bus.ldr_done, 4'b0001)
    q.delete();

    // odd byte count: trailing low byte flushed with zero high byte, channel 2
    start_dl(8'd2);
    send_byte(25'd0, 8'hAA); send_byte(25'd1, 8'hBB); send_byte(25'd2, 8'hCC);
    end_dl();
    wait_idle();
    `CHK("b_nwr", q.size(), 2)
    if (q.size() == 2) begin
      `CHK("b_w0_dat",  q[0].d, 16'hBBAA)
      `CHK("b_w1_addr", q[1].a, 20'd1)
      `CHK("b_w1_dat",  q[1].d, 16'h00CC)
      `CHK("b_w1_ch",   q[1].c, 3'd2)
    end
    `CHK("b_done", bus.ldr_done, 4'b0101)
    `CHK("b_sum",  bus.ldr_sum, exp_sum)
    q.delete();

    // backpressure: ack held low, stream 20 bytes on channel 1
    auto_mode = 1'b0; man_ack = 1'b0;
    start_dl(8'd1);
    i = 0; seen = 1'b0; words_at = -1;
    while (i < 20 && !seen) begin
      @(negedge clk_sys);
      if (bus.ioctl_wait) begin
        seen = 1'b1; words_at = i / 2;
      end else begin
        bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(i * 3 + 1); bus.ioctl_wr = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        i++;
      end
    end
    `CHK("c_wait_seen", seen, 1'b1)
    `CHK("c_wait_at",   words_at, 6)
    `CHK("c_presented", q.size(), 1)
    auto_mode = 1'b1;
    while (i < 20) begin
      send_byte(25'(i), 8'(i * 3 + 1));
      i++;
    end
    end_dl();
    wait_idle();
    `CHK("c_nwr", q.size(), 10)
    ok = (q.size() == 10);
    for (int k = 0; k < 10 && ok; k++) begin
      b_lo = 8'(2 * k * 3 + 1);
      b_hi = 8'((2 * k + 1) * 3 + 1);
      if (q[k].a !== 20'(k) || q[k].d !== {b_hi, b_lo} || q[k].c !== 3'd1) ok = 1'b0;
    end
    `CHK("c_order", ok, 1'b1)
    `CHK("c_done",  bus.ldr_done, 4'b0111)
    q.delete();

    // ack level held high: second word needs a fresh rising edge, channel 3
    auto_mode = 1'b0; man_ack = 1'b0;
    start_dl(8'd3);
    send_byte(25'd0, 8'h01); send_byte(25'd1, 8'h02);
    send_byte(25'd2, 8'h03); send_byte(25'd3, 8'h04);
    wait_wr();
    man_ack = 1'b1;
    repeat (6) @(negedge clk_sys);
    `CHK("d_held_wr",  bus.ldr_wr, 1'b1)
    `CHK("d_held_nwr", q.size(), 2)
    `CHK("d_held_adr", bus.ldr_addr, 20'd1)
    man_ack = 1'b0;
    @(negedge clk_sys);
    man_ack = 1'b1;
    @(negedge clk_sys);
    man_ack = 1'b0;
    end_dl();
    wait_idle();
    `CHK("d_nwr", q.size(), 2)
    if (q.size() == 2) `CHK("d_w1_dat", q[1].d, 16'h0403)
    `CHK("d_done", bus.ldr_done, 4'b1111)
    q.delete();

    // out-of-range index is ignored
    auto_mode = 1'b1;
    start_dl(8'd5);
    send_byte(25'd0, 8'h77); send_byte(25'd1, 8'h88);
    `CHK("e_busy", bus.ldr_busy,   1'b0)
    `CHK("e_wait", bus.ioctl_wait, 1'b0)
    end_dl();
    repeat (4) @(negedge clk_sys);
    `CHK("e_nwr",  q.size(), 0)
    `CHK("e_done", bus.ldr_done, 4'b1111)

    // reset mid-transfer after two of four words complete
    auto_mode = 1'b0; man_ack = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 8; k++) send_byte(25'(k), 8'(8'h90 + k));
    ack_pulse();
    ack_pulse();
    wait_wr();
    #2;
    bus.ioctl_download = 1'b0;
    reset = 1'b1;
    #1;
    `CHK("f_rst_wr",   bus.ldr_wr,   1'b0)
    `CHK("f_rst_done", bus.ldr_done, 4'h0)
    `CHK("f_rst_busy", bus.ldr_busy, 1'b0)
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    `CHK("f_no_wr", q.size(), 3)
    `CHK("f_wr_lo", bus.ldr_wr, 1'b0)
    q.delete();
    auto_mode = 1'b1;
    start_dl(8'd1);
    send_byte(25'd0, 8'h55); send_byte(25'd1, 8'h66);
    end_dl();
    wait_idle();
    `CHK("f_nwr", q.size(), 1)
    if (q.size() == 1) begin
      `CHK("f_w0_dat", q[0].d, 16'h6655)
      `CHK("f_w0_ch",  q[0].c, 3'd1)
    end
    `CHK("f_done", bus.ldr_done, 4'b0010)

    `CHK("hold_stable", stab_err, 0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
